// File: rtl/prach_fft_sched_pkg.sv
// Shared types and helpers for the PRACH FFT frame scheduler.
// Holds the FSM state type, FFT length constants and width helpers.
package prach_fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } sched_state_t;

    localparam int FFT_LEN_LOG2 = 6;
    localparam int FFT_POINTS   = 1 << FFT_LEN_LOG2;

    function automatic int fft_points(input int n);
        return 1 << n;
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prach_fft_sched_if.sv
// Request/grant and buffer-read/framing bundle of the FFT scheduler.
// master = scheduler side, slave = buffers/FFT side.
interface prach_fft_sched_if
    import prach_fft_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int NUM_FFT_LENGTH = 6
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                      en;
    logic [NUM_CH-1:0]         req;
    logic [NUM_CH-1:0]         grant;
    logic                      rd_en;
    logic [CH_W-1:0]           rd_ch;
    logic [NUM_FFT_LENGTH-1:0] rd_addr;
    logic                      fft_dv;
    logic                      fft_sync;
    logic                      fft_sync_ahead;
    logic                      frame_done;
    logic                      busy;

    modport master (
        input  en,
        input  req,
        output grant,
        output rd_en,
        output rd_ch,
        output rd_addr,
        output fft_dv,
        output fft_sync,
        output fft_sync_ahead,
        output frame_done,
        output busy
    );

    modport slave (
        output en,
        output req,
        input  grant,
        input  rd_en,
        input  rd_ch,
        input  rd_addr,
        input  fft_dv,
        input  fft_sync,
        input  fft_sync_ahead,
        input  frame_done,
        input  busy
    );

endinterface

// File: rtl/prach_rr_arbiter.sv
// Round-robin arbiter; the search starts one past the last grant.
// The pointer moves only when advance is asserted.
module prach_rr_arbiter
    import prach_fft_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] cand;
    logic            found;

    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant = (en && found) ? (NUM_CH'(1) << idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/prach_fft_sched.sv
// Shares one FFT chain among NUM_CH buffers: arbitrates, reads a frame,
// and emits dv/sync framing delayed to match the buffer read latency.
module prach_fft_sched
    import prach_fft_pkg::*;
#(
    parameter int NUM_FFT_LENGTH = 6,
    parameter int NUM_CH         = 4,
    parameter int NUM_GAP        = 2,
    parameter int RD_LATENCY     = 2
) (
    input logic               clk,
    input logic               rst,
    prach_fft_sched_if.master bus
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam int PTS  = fft_points(NUM_FFT_LENGTH);
    localparam logic [NUM_FFT_LENGTH-1:0] LAST =
        NUM_FFT_LENGTH'(PTS - 1);
    localparam logic [3:0] GAP_END = 4'(NUM_GAP - 1);

    sched_state_t              state;
    sched_state_t              state_nxt;
    logic [NUM_FFT_LENGTH-1:0] addr;
    logic [3:0]                gap_cnt;
    logic [CH_W-1:0]           rd_ch_q;
    logic [NUM_CH-1:0]         arb_grant;
    logic [CH_W-1:0]           arb_idx;
    logic                      arb_en;
    logic                      go;
    logic                      rd_en;
    logic                      first;
    logic                      last;
    logic [RD_LATENCY-1:0]     dv_sr;
    logic [RD_LATENCY-1:0]     first_sr;
    logic [RD_LATENCY-1:0]     last_sr;

    // rst gating keeps the combinational grant quiet during reset
    assign arb_en = (state == IDLE) && bus.en && !rst;
    assign go     = |arb_grant;

    prach_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .en      (arb_en),
        .advance (go),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == IDLE: begin
                if (go) state_nxt = RUN;
            end
            state == RUN: begin
                if (addr == LAST)
                    state_nxt = (NUM_GAP == 0) ? IDLE : GAP;
            end
            state == GAP: begin
                if (gap_cnt == GAP_END) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            gap_cnt <= '0;
            rd_ch_q <= '0;
        end else begin
            state   <= state_nxt;
            if (state == RUN) addr <= addr + 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 4'd0;
            if (go) rd_ch_q <= arb_idx;
        end
    end

    assign rd_en = (state == RUN);
    assign first = rd_en && (addr == '0);
    assign last  = rd_en && (addr == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_sr    <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            dv_sr[0]    <= rd_en;
            first_sr[0] <= first;
            last_sr[0]  <= last;
            for (int k = 1; k < RD_LATENCY; k++) begin
                dv_sr[k]    <= dv_sr[k-1];
                first_sr[k] <= first_sr[k-1];
                last_sr[k]  <= last_sr[k-1];
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_ahead_direct
            assign bus.fft_sync_ahead = first;
        end else begin : g_ahead_delayed
            assign bus.fft_sync_ahead = first_sr[RD_LATENCY-2];
        end
    endgenerate

    assign bus.grant      = arb_grant;
    assign bus.rd_en      = rd_en;
    assign bus.rd_ch      = rd_ch_q;
    assign bus.rd_addr    = addr;
    assign bus.fft_dv     = dv_sr[RD_LATENCY-1];
    assign bus.fft_sync   = first_sr[RD_LATENCY-1];
    assign bus.frame_done = last_sr[RD_LATENCY-1];
    assign bus.busy       = (state != IDLE) || (|dv_sr);

endmodule
